// File: rtl/store_buffer_pkg.sv
// ----------------------------------------------------------------------------
// store_buffer_pkg
//   Shared definitions for the store buffer slice: default address/data
//   widths, the word-offset bit count and the queued-store entry type.
// ----------------------------------------------------------------------------
package store_buffer_pkg;

    localparam int AW_DEF   = 32;  // default address width
    localparam int DW_DEF   = 32;  // default data width
    localparam int WORD_OFF = 2;   // byte-offset bits below a word address

    // One queued store: word-aligned address plus full-word data.
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } sb_entry_t;

endpackage : store_buffer_pkg

// File: rtl/sb_forward_match.sv
// ----------------------------------------------------------------------------
// sb_forward_match
//   Store-to-load forwarding search. Walks the valid entries from oldest
//   (head) to youngest (head+count-1), letting each later match override an
//   earlier one, so the youngest matching store wins and pointer wrap is
//   honoured by construction.
//
// Ports:
//   ent_addr_i  in  AW x DEPTH  queued store addresses
//   ent_data_i  in  DW x DEPTH  queued store data
//   head_i      in  log2(DEPTH) index of the oldest entry
//   count_i     in  log2(DEPTH)+1 number of valid entries
//   ld_addr_i   in  AW          load address
//   hit_o       out 1           some valid entry holds the load's word
//   hit_data_o  out DW          data of the youngest matching entry
// ----------------------------------------------------------------------------
module sb_forward_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic [AW-1:0]            ent_addr_i [DEPTH],
    input  logic [DW-1:0]            ent_data_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [$clog2(DEPTH):0]   count_i,
    input  logic [AW-1:0]            ld_addr_i,
    output logic                     hit_o,
    output logic [DW-1:0]            hit_data_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // NOTE: every variable written in an always_comb gets a default on entry;
    // a path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Age order: i = 0 is the oldest entry; index wraps naturally.
            idx = head_i + PW'(i);
            // Compare word addresses only; the XOR-then-shift drops byte bits.
            if (((PW+1)'(i) < count_i) &&
                (((ent_addr_i[idx] ^ ld_addr_i) >> WORD_OFF) == '0)) begin
                hit_o      = 1'b1;
                hit_data_o = ent_data_i[idx];
            end
        end
    end

endmodule : sb_forward_match

// File: rtl/store_buffer.sv
// ----------------------------------------------------------------------------
// store_buffer
//   Word store queue between the EX/MEM register and data memory. Stores are
//   queued and drained one per cycle whenever no load owns the memory port.
//   Loads forward from the youngest matching queued store, otherwise read
//   memory directly, all in the same cycle. The pipeline is stalled only when
//   a store arrives while the queue is full.
//
// Ports:
//   clk_i        in   rising-edge clock
//   rst_i        in   asynchronous active-low reset
//   addr_i       in   load/store byte address (word aligned)
//   data_i       in   store data
//   MemRead_i    in   load request
//   MemWrite_i   in   store request
//   data_o       out  load result (combinational, 0 when no load)
//   stall_o      out  store not accepted this cycle
//   empty_o      out  queue empty
//   mem_addr_o   out  data memory address
//   mem_data_o   out  data memory write data
//   mem_read_o   out  data memory read enable
//   mem_write_o  out  data memory write enable
//   mem_data_i   in   data memory read data (combinational)
// ----------------------------------------------------------------------------
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic          MemRead_i,
    input  logic          MemWrite_i,
    output logic [DW-1:0] data_o,
    output logic          stall_o,
    output logic          empty_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    input  logic [DW-1:0] mem_data_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] ent_addr_q [DEPTH];
    logic [AW-1:0] ent_addr_d [DEPTH];
    logic [DW-1:0] ent_data_q [DEPTH];
    logic [DW-1:0] ent_data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // Full is judged on the registered count, so a same-cycle drain never
    // frees a slot for the incoming store.
    assign push  = MemWrite_i && !full;
    // A load owns the memory port; draining waits for a load-free cycle.
    assign pop   = !empty && !MemRead_i;

    // ---------------- next-state ----------------
    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (push) begin
            ent_addr_d[tail_q] = {addr_i[AW-1:WORD_OFF], {WORD_OFF{1'b0}}};
            ent_data_d[tail_q] = data_i;
            tail_d             = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ---------------- state ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: the entry arrays are cleared on reset so that a reset
            // mid-operation leaves no stale store data behind; the valid
            // window (count) alone already discards pending stores.
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ent_addr_q <= ent_addr_d;
            ent_data_q <= ent_data_d;
        end
    end

    // ---------------- forwarding ----------------
    // Searches the pre-push contents, so a same-cycle store never forwards.
    sb_forward_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .ent_addr_i (ent_addr_q),
        .ent_data_i (ent_data_q),
        .head_i     (head_q),
        .count_i    (count_q),
        .ld_addr_i  (addr_i),
        .hit_o      (fwd_hit),
        .hit_data_o (fwd_data)
    );

    // ---------------- outputs ----------------
    // Everything is forced quiet while reset is asserted, including a load
    // request that happens to be present.
    always_comb begin
        data_o      = '0;
        stall_o     = 1'b0;
        empty_o     = 1'b1;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        if (rst_i) begin
            stall_o = MemWrite_i && full;
            empty_o = empty;
            if (MemRead_i) begin
                mem_read_o = 1'b1;
                mem_addr_o = addr_i;
                data_o     = fwd_hit ? fwd_data : mem_data_i;
            end else if (pop) begin
                mem_write_o = 1'b1;
                mem_addr_o  = ent_addr_q[head_q];
                mem_data_o  = ent_data_q[head_q];
            end
        end
    end

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// ----------------------------------------------------------------------------
// tb_store_buffer
//   Scoreboard bench for store_buffer. Stimulus pushes the expected memory
//   writes and load results into queues; a monitor pops and compares them
//   whenever the DUT asserts mem_write_o or mem_read_o.
// ----------------------------------------------------------------------------
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        empty_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_data_i;

    int total = 0;
    int bad   = 0;

    sb_entry_t   exp_wr [$];
    logic [31:0] exp_ld [$];

    logic [31:0] mem [64];

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .data_o      (data_o),
        .stall_o     (stall_o),
        .empty_o     (empty_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_data_i  (mem_data_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory model: combinational read, write on the rising edge.
    assign mem_data_i = mem[mem_addr_o[7:2]];
    always @(posedge clk) begin
        if (mem_write_o) mem[mem_addr_o[7:2]] <= mem_data_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every memory write and every load result.
    always @(negedge clk) begin
        if (mem_write_o) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", mem_addr_o, 32'hFFFF_FFFF);
            end else begin
                sb_entry_t e;
                e = exp_wr.pop_front();
                check("wr_addr", mem_addr_o, e.addr);
                check("wr_data", mem_data_o, e.data);
            end
        end
        if (mem_read_o) begin
            if (exp_ld.size() == 0) begin
                check("unexpected_load", data_o, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] v;
                v = exp_ld.pop_front();
                check("ld_data", data_o, v);
                check("ld_blocks_drain", {31'b0, mem_write_o}, 32'd0);
            end
        end
        if (dut.count_q > DEPTH) begin
            bad++;
            $display("FAIL count_invariant: got %0d expected <= %0d", dut.count_q, DEPTH);
        end
    end

    // Apply one cycle of inputs and check stall; outputs are examined at the
    // falling edge, inputs change just after the rising edge.
    task automatic op_begin(input logic we, input logic re, input logic [31:0] a,
                            input logic [31:0] d, input logic push_wr,
                            input logic [31:0] exp_rd, input logic exp_stall);
        sb_entry_t e;
        if (push_wr) begin
            e.addr = a;
            e.data = d;
            exp_wr.push_back(e);
        end
        if (re) exp_ld.push_back(exp_rd);
        MemWrite_i = we;
        MemRead_i  = re;
        addr_i     = a;
        data_i     = d;
        @(negedge clk);
        check("stall", {31'b0, stall_o}, {31'b0, exp_stall});
    endtask

    task automatic op_end();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] d, input logic push_wr,
                      input logic [31:0] exp_rd, input logic exp_stall);
        op_begin(we, re, a, d, push_wr, exp_rd, exp_stall);
        op_end();
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (!empty_o && n < 20) begin
            op(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
            n++;
        end
        check("drain_empty", {31'b0, empty_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;

        // ---- reset, with requests present that must be ignored ----
        rst_i      = 1'b0;
        MemWrite_i = 1'b1;
        MemRead_i  = 1'b1;
        addr_i     = 32'h40;
        data_i     = 32'h1234_5678;
        @(negedge clk);
        check("rst_mem_read",  {31'b0, mem_read_o},  32'd0);
        check("rst_mem_write", {31'b0, mem_write_o}, 32'd0);
        check("rst_data_o",    data_o,               32'd0);
        check("rst_mem_addr",  mem_addr_o,           32'd0);
        check("rst_stall",     {31'b0, stall_o},     32'd0);
        check("rst_empty",     {31'b0, empty_o},     32'd1);
        repeat (2) @(posedge clk);
        #1;
        MemWrite_i = 1'b0;
        MemRead_i  = 1'b0;
        addr_i     = '0;
        data_i     = '0;
        rst_i      = 1'b1;

        // ---- idle after reset ----
        op_begin(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("idle_empty",     {31'b0, empty_o},     32'd1);
        check("idle_mem_write", {31'b0, mem_write_o}, 32'd0);
        check("idle_mem_read",  {31'b0, mem_read_o},  32'd0);
        check("idle_data_o",    data_o,               32'd0);
        op_end();

        // ---- single store drains the following cycle ----
        op_begin(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
        check("st_latency_no_write", {31'b0, mem_write_o}, 32'd0);
        op_end();
        op_begin(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("st_drain_write", {31'b0, mem_write_o}, 32'd1);
        check("st_not_empty",   {31'b0, empty_o},     32'd0);
        op_end();
        op_begin(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("st_empty_after", {31'b0, empty_o}, 32'd1);
        op_end();

        // ---- forwarding: youngest wins, miss reads memory ----
        op(1'b1, 1'b1, 32'h20, 32'h1111_1111, 1'b1, 32'hA500_0008, 1'b0);
        op(1'b1, 1'b1, 32'h20, 32'h2222_2222, 1'b1, 32'h1111_1111, 1'b0);
        op(1'b0, 1'b1, 32'h20, 32'h0,         1'b0, 32'h2222_2222, 1'b0);
        op_begin(1'b0, 1'b1, 32'h24, 32'h0, 1'b0, 32'hA500_0009, 1'b0);
        check("ld_mem_addr", mem_addr_o, 32'h24);
        op_end();
        wait_empty();

        // ---- full / stall ----
        for (int k = 0; k < 4; k++)
            op(1'b1, 1'b1, 32'h30 + 4*k, 32'h3000_0030 + 4*k, 1'b1, 32'hA500_000C + k, 1'b0);
        op(1'b1, 1'b1, 32'h40, 32'h3000_0040, 1'b0, 32'hA500_0010, 1'b1);
        op(1'b1, 1'b0, 32'h40, 32'h3000_0040, 1'b0, 32'h0, 1'b1);
        op(1'b1, 1'b0, 32'h40, 32'h3000_0040, 1'b1, 32'h0, 1'b0);
        wait_empty();

        // ---- wrap-around with forwarding across the rollover ----
        op(1'b1, 1'b1, 32'h00, 32'h5A00_0000, 1'b1, 32'hA500_0000, 1'b0);
        op(1'b1, 1'b1, 32'h04, 32'h5A00_0001, 1'b1, 32'hA500_0001, 1'b0);
        op(1'b1, 1'b1, 32'h08, 32'h5A00_0002, 1'b1, 32'hA500_0002, 1'b0);
        op(1'b1, 1'b0, 32'h0C, 32'h5A00_0003, 1'b1, 32'h0,         1'b0);
        op(1'b1, 1'b1, 32'h10, 32'h5A00_0004, 1'b1, 32'hDEAD_BEEF, 1'b0);
        op(1'b0, 1'b1, 32'h04, 32'h0,         1'b0, 32'h5A00_0001, 1'b0);
        op(1'b0, 1'b1, 32'h10, 32'h0,         1'b0, 32'h5A00_0004, 1'b0);
        op(1'b1, 1'b1, 32'h14, 32'h5A00_0005, 1'b0, 32'hA500_0005, 1'b1);
        op(1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         1'b0);
        op(1'b1, 1'b0, 32'h14, 32'h5A00_0005, 1'b1, 32'h0,         1'b0);
        op(1'b1, 1'b0, 32'h18, 32'h5A00_0006, 1'b1, 32'h0,         1'b0);
        op(1'b1, 1'b1, 32'h1C, 32'h5A00_0007, 1'b1, 32'hA500_0007, 1'b0);
        op(1'b0, 1'b1, 32'h14, 32'h0,         1'b0, 32'h5A00_0005, 1'b0);
        op(1'b1, 1'b1, 32'h20, 32'h5A00_0008, 1'b0, 32'h2222_2222, 1'b1);
        op(1'b1, 1'b0, 32'h20, 32'h5A00_0008, 1'b0, 32'h0,         1'b1);
        op(1'b1, 1'b0, 32'h20, 32'h5A00_0008, 1'b1, 32'h0,         1'b0);
        op(1'b1, 1'b1, 32'h1C, 32'h5A00_00CC, 1'b1, 32'h5A00_0007, 1'b0);
        op(1'b0, 1'b1, 32'h1C, 32'h0,         1'b0, 32'h5A00_00CC, 1'b0);
        op(1'b0, 1'b1, 32'h20, 32'h0,         1'b0, 32'h5A00_0008, 1'b0);
        op(1'b1, 1'b0, 32'h24, 32'h5A00_0009, 1'b0, 32'h0,         1'b1);
        op(1'b1, 1'b0, 32'h24, 32'h5A00_0009, 1'b1, 32'h0,         1'b0);
        wait_empty();
        for (int k = 0; k < 10; k++)
            check("wrap_mem", mem[k], (k == 7) ? 32'h5A00_00CC : (32'h5A00_0000 + k));

        // ---- reset mid-drain: only the first store reaches memory ----
        op(1'b1, 1'b1, 32'h80, 32'hBB00_0080, 1'b1, 32'hA500_0020, 1'b0);
        op(1'b1, 1'b1, 32'h84, 32'hBB00_0084, 1'b0, 32'hA500_0021, 1'b0);
        op(1'b1, 1'b1, 32'h88, 32'hBB00_0088, 1'b0, 32'hA500_0022, 1'b0);
        op(1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         1'b0);
        rst_i = 1'b0;
        @(negedge clk);
        check("mid_rst_empty", {31'b0, empty_o},     32'd1);
        check("mid_rst_write", {31'b0, mem_write_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        for (int k = 0; k < 5; k++) op(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("post_rst_empty", {31'b0, empty_o}, 32'd1);
        check("mid_mem_80", mem[32], 32'hBB00_0080);
        check("mid_mem_84", mem[33], 32'hA500_0021);
        check("mid_mem_88", mem[34], 32'hA500_0022);

        check("wr_queue_left", exp_wr.size(), 32'd0);
        check("ld_queue_left", exp_ld.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_store_buffer
